// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Quotient returned for a zero divisor is this bit replicated to full width.
    localparam logic DIV_ZERO_Q_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/prefix_subtractor.sv
// Combinational a - b as a + ~b + 1 with a Kogge-Stone carry tree.
// no_borrow is the carry-out: 1 when a >= b.
module prefix_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    localparam int LEVELS = $clog2(W);

    logic [W-1:0] bn;
    logic [W-1:0] p0;
    logic [W-1:0] g_lvl [0:LEVELS];
    logic [W-1:0] p_lvl [0:LEVELS];
    logic [W-1:0] carry;

    assign bn = ~b;
    assign p0 = a ^ bn;

    // The forced carry-in is folded into bit 0: it generates if it propagates.
    assign g_lvl[0] = (a & bn) | {{(W-1){1'b0}}, p0[0]};
    assign p_lvl[0] = p0;

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_prefix
            localparam int SPAN = 1 << gi;
            localparam logic [W-1:0] LOW_MASK = {W{1'b1}} >> (W - SPAN);
            assign g_lvl[gi+1] = g_lvl[gi] | (p_lvl[gi] & (g_lvl[gi] << SPAN));
            assign p_lvl[gi+1] = p_lvl[gi] & ((p_lvl[gi] << SPAN) | LOW_MASK);
        end
    endgenerate

    assign carry     = {g_lvl[LEVELS][W-2:0], 1'b1};
    assign diff      = p0 ^ carry;
    assign no_borrow = g_lvl[LEVELS][W-1];

endmodule

// File: rtl/seq_divider_32.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and result.
module seq_divider_32
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             dbz_reg;

    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   diff;
    logic             nb;
    logic             unused_diff_msb;

    // Partial remainder shifted left with the next dividend bit; WIDTH+1 bits so no MSB is lost.
    assign t_val = {r_reg, q_reg[WIDTH-1]};

    prefix_subtractor #(
        .W(WIDTH + 1)
    ) u_sub (
        .a         (t_val),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .no_borrow (nb)
    );

    // R < D keeps the true difference below 2^WIDTH whenever nb is set.
    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        d_reg   <= divisor;
                        cnt_reg <= '0;
                        if (divisor == '0) begin
                            q_reg     <= {WIDTH{DIV_ZERO_Q_FILL}};
                            r_reg     <= dividend;
                            dbz_reg   <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            q_reg     <= dividend;
                            r_reg     <= '0;
                            dbz_reg   <= 1'b0;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_reg   <= nb ? diff[WIDTH-1:0] : t_val[WIDTH-1:0];
                    q_reg   <= {q_reg[WIDTH-2:0], nb};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dbz_reg;

endmodule
